// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative RV32M multiply/divide unit. It uses a start/valid handshake: the
//   control unit pulses alu_start, waits for valid, then takes result.
//   Multiplies use a shift-add engine. Divides use a restoring shift-subtract
//   engine. Both run one bit per cycle on the same hi/lo/b registers.
//   Divide-by-zero and signed overflow are resolved at accept and skip RUN.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   alu_start  one-cycle request, accepted in IDLE or DONE
//   opcode     RV32M funct3 (0 MUL .. 7 REMU)
//   alu_in1    rs1 operand (multiplicand / dividend)
//   alu_in2    rs2 operand (multiplier / divisor)
//   result     registered result, held until the next request completes
//   valid      high for the single DONE cycle
//   busy       high while iterating (RUN)
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_start,
  input  logic [2:0]       opcode,
  input  logic [width-1:0] alu_in1,
  input  logic [width-1:0] alu_in2,
  output logic [width-1:0] result,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(width + 1);
  localparam logic [width-1:0] MIN_NEG = {1'b1, {(width-1){1'b0}}};

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [2:0]       op;
  logic [width-1:0] hi, lo, b_reg;
  logic             neg_res, neg_rem;

  // ---------------------------------------------------------------------------
  // Accept-side decode: sign handling and special cases
  // ---------------------------------------------------------------------------
  logic             accept, in1_signed, in2_signed, s1, s2;
  logic             div_zero, overflow, special;
  logic [width-1:0] abs1, abs2, special_result;

  assign accept     = alu_start && (state != RUN);
  // Divides: even opcodes are signed. Multiplies: MULHU is fully unsigned, and
  // MULHSU treats only rs1 as signed.
  assign in1_signed = opcode[2] ? ~opcode[0] : (opcode[1:0] != 2'd3);
  assign in2_signed = opcode[2] ? ~opcode[0] : ~opcode[1];
  assign s1         = in1_signed & alu_in1[width-1];
  assign s2         = in2_signed & alu_in2[width-1];
  assign abs1       = s1 ? -alu_in1 : alu_in1;
  assign abs2       = s2 ? -alu_in2 : alu_in2;

  assign div_zero = opcode[2] && (alu_in2 == '0);
  assign overflow = opcode[2] && !opcode[0] && (alu_in1 == MIN_NEG) && (alu_in2 == '1);
  assign special  = div_zero || overflow;
  // opcode[1] selects the remainder flavour (REM/REMU).
  assign special_result = div_zero ? (opcode[1] ? alu_in1 : '1)
                                   : (opcode[1] ? '0 : alu_in1);

  // ---------------------------------------------------------------------------
  // One iteration of the shared datapath
  //   multiply: {hi,lo} = partial product, lo starts as the multiplier
  //   divide  : hi = partial remainder, lo = dividend shifting into quotient
  // ---------------------------------------------------------------------------
  logic [width:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [width-1:0] div_diff, hi_nxt, lo_nxt;

  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : '0);
  assign div_shift = {hi, lo[width-1]};
  assign div_ge    = div_shift >= {1'b0, b_reg};
  // When div_ge is set, the true difference fits in width bits, so the
  // modular subtraction on the low bits is exact.
  assign div_diff  = div_shift[width-1:0] - b_reg;

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned. Otherwise a latch would be inferred.
    hi_nxt = hi;
    lo_nxt = lo;
    if (op[2]) begin
      hi_nxt = div_ge ? div_diff : div_shift[width-1:0];
      lo_nxt = {lo[width-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[width:1];
      lo_nxt = {mul_sum[0], lo[width-1:1]};
    end
  end

  // Sign fixup applied to the values produced by the final iteration.
  logic [2*width-1:0] prod, prod_fix;
  logic [width-1:0]   q_fix, r_fix, final_result;

  assign prod     = {hi_nxt, lo_nxt};
  assign prod_fix = neg_res ? -prod : prod;
  assign q_fix    = neg_res ? -lo_nxt : lo_nxt;
  assign r_fix    = neg_rem ? -hi_nxt : hi_nxt;

  always_comb begin
    final_result = '0;
    case (op)
      3'd0:                final_result = prod_fix[width-1:0];
      3'd1, 3'd2, 3'd3:    final_result = prod_fix[2*width-1:width];
      default:             final_result = op[1] ? r_fix : q_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state always uses non-blocking assignment. This lets
    // every register update from the values seen before the clock edge.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : RUN;
      RUN:     if (count == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = accept ? (special ? DONE : RUN) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign valid = (state == DONE);
  assign busy  = (state == RUN);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: reset clears all datapath registers, including the operand
    // registers. An abandoned request therefore leaves no residue.
    if (!rst) begin
      result  <= '0;
      count   <= '0;
      op      <= '0;
      hi      <= '0;
      lo      <= '0;
      b_reg   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      op      <= opcode;
      count   <= CW'(width);
      neg_res <= s1 ^ s2;
      neg_rem <= s1;
      hi      <= '0;
      if (opcode[2]) begin
        lo    <= abs1;
        b_reg <= abs2;
      end else begin
        lo    <= abs2;
        b_reg <= abs1;
      end
      if (special) result <= special_result;
    end else if (state == RUN) begin
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      count <= count - CW'(1);
      if (count == CW'(1)) result <= final_result;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Self-checking bench for mul_div_unit (width = 32). It applies a table of
//   hand-computed vectors, a set of hand-written handshake/reset sequences, and
//   boundary and random sweeps checked against a behavioural RV32M model.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_start = 1'b0;
  logic [2:0]  opcode = '0;
  logic [31:0] alu_in1 = '0;
  logic [31:0] alu_in2 = '0;
  logic [31:0] result;
  logic        valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.width(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_start (alu_start),
    .opcode    (opcode),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .result    (result),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural RV32M reference built on the language's 64-bit arithmetic.
  function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int          ia, ib;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (op[2] && (b == 0)) return 0;
    if (op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 0;
    return 32;
  endfunction

  // Drives a request so that the next rising edge accepts it. Afterwards the
  // inputs are scrambled to show that they only matter at that edge.
  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    opcode    = op;
    alu_in1   = a;
    alu_in2   = b;
    alu_start = 1'b1;
    @(posedge clk);
    #1;
    alu_start = 1'b0;
    opcode    = 3'($urandom);
    alu_in1   = $urandom;
    alu_in2   = $urandom;
  endtask

  // Counts the edges after the accepting edge until valid is seen. Sampling
  // happens on falling edges. k = 0 means valid right after the accept edge.
  task automatic wait_valid(output int k);
    k = 0;
    @(negedge clk);
    while (!valid && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_vec(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] exp, int lat);
    int k;
    issue(op, a, b);
    wait_valid(k);
    check({name, " latency"}, 32'(k), 32'(lat));
    check({name, " result"}, result, exp);
    @(negedge clk);
    check({name, " pulse"}, {31'b0, valid}, 32'd0);
  endtask

  logic [31:0] bnd [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return bnd[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    vec_t        vecs[$];
    int          k;
    int          pulses;
    logic [2:0]  op;
    logic [31:0] a, b;

    vecs.push_back('{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 32, "mul -2*3"});
    vecs.push_back('{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32, "mulh -2*3"});
    vecs.push_back('{3'd3, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32, "mulhu fffffffe*3"});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, "mulhsu -1*ffffffff"});
    vecs.push_back('{3'd0, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32, "mul max*2"});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, "mulhu ones*ones"});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, "mulh min*min"});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32, "div -7/2"});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32, "rem -7/2"});
    vecs.push_back('{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32, "divu fffffff9/2"});
    vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2,         32, "remu 100/7"});
    vecs.push_back('{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, "div 7/-2"});
    vecs.push_back('{3'd6, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32, "rem 7/-2"});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32, "div min/1"});
    vecs.push_back('{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 0,  "div 5/0"});
    vecs.push_back('{3'd6, 32'd5,         32'd0,         32'd5,         0,  "rem 5/0"});
    vecs.push_back('{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 0,  "divu 5/0"});
    vecs.push_back('{3'd7, 32'd5,         32'd0,         32'd5,         0,  "remu 5/0"});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,  "div overflow"});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0,  "rem overflow"});

    // Reset state
    repeat (2) @(negedge clk);
    check("reset result", result, 32'd0);
    check("reset valid", {31'b0, valid}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table
    foreach (vecs[i])
      run_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // alu_start held high through RUN with changing operands: one request only
    opcode    = 3'd0;
    alu_in1   = 32'd7;
    alu_in2   = 32'd6;
    alu_start = 1'b1;
    @(posedge clk);
    #1;
    alu_in1 = 32'd1000;
    alu_in2 = 32'd1000;
    opcode  = 3'd5;
    k = 0;
    @(negedge clk);
    check("held busy", {31'b0, busy}, 32'd1);
    while (!valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    alu_start = 1'b0;
    check("held latency", 32'(k), 32'd32);
    check("held result", result, 32'd42);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("held extra pulses", 32'(pulses), 32'd0);

    // Back-to-back: a start in the DONE cycle is accepted
    issue(3'd3, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_valid(k);
    check("b2b first result", result, 32'd2);
    issue(3'd5, 32'd9, 32'd3);
    wait_valid(k);
    check("b2b divu latency", 32'(k), 32'd32);
    check("b2b divu result", result, 32'd3);
    issue(3'd4, 32'd5, 32'd0);
    wait_valid(k);
    check("b2b special latency", 32'(k), 32'd0);
    check("b2b special result", result, 32'hFFFF_FFFF);
    @(negedge clk);
    check("b2b pulse", {31'b0, valid}, 32'd0);

    // Reset mid-RUN abandons the request
    issue(3'd0, 32'd3, 32'd5);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst valid", {31'b0, valid}, 32'd0);
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("midrst pulses", 32'(pulses), 32'd0);
    run_vec("post reset mul 3*5", 3'd0, 32'd3, 32'd5, 32'd15, 32);

    // Boundary cross product
    for (int o = 0; o < 8; o++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) begin
          op = 3'(o);
          run_vec($sformatf("bnd op%0d %h %h", o, bnd[i], bnd[j]), op, bnd[i], bnd[j],
                  model(op, bnd[i], bnd[j]), model_lat(op, bnd[i], bnd[j]));
        end

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run_vec($sformatf("rnd%0d op%0d %h %h", i, op, a, b), op, a, b,
              model(op, a, b), model_lat(op, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
